// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds the 8-digit seven-segment scanner; out-of-range inputs show as all-E digits.
module bin2bcd_seq #(
  parameter int          DATA_W  = 27,
  parameter int          DIGITS  = 8,
  parameter logic [31:0] MAX_VAL = 32'd99999999
) (
  input  logic        clk_axi,
  input  logic        reset,
  input  logic [31:0] bin_in,
  input  logic        bin_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [31:0] bcd_out,
  output logic        done,
  output logic        overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_next;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    bcd_out_d  = bcd_out_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    // One double-dabble step: correct every nibble >= 5, then shift the whole register.
    bcd_adj = sr_q[SR_W-1 -: BCD_W];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    sr_adj  = {bcd_adj, sr_q[DATA_W-1:0]};
    sr_next = sr_adj << 1;

    case (state_q)
      S_IDLE: begin
        if (bin_valid) begin
          if (bin_in > MAX_VAL) begin
            bcd_out_d  = {DIGITS{4'hE}};
            overflow_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            sr_d       = {{BCD_W{1'b0}}, bin_in[DATA_W-1:0]};
            cnt_d      = '0;
            overflow_d = 1'b0;
            state_d    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sr_d  = sr_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          bcd_out_d = sr_next[SR_W-1 -: BCD_W];
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk_axi) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      bcd_out_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign bcd_out  = bcd_out_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq against a divide-by-ten BCD reference.
module tb_bin2bcd_seq;

  logic        clk_axi;
  logic        reset;
  logic [31:0] bin_in;
  logic        bin_valid;
  logic        in_ready;
  logic        busy;
  logic [31:0] bcd_out;
  logic        done;
  logic        overflow;

  int          n_tests;
  int          n_fail;
  int          done_cnt;
  logic [31:0] prev_bcd;

  bin2bcd_seq dut (
    .clk_axi  (clk_axi),
    .reset    (reset),
    .bin_in   (bin_in),
    .bin_valid(bin_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .bcd_out  (bcd_out),
    .done     (done),
    .overflow (overflow)
  );

  initial clk_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  always @(negedge clk_axi) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bcd_ref(input logic [31:0] v);
    logic [31:0] r;
    int unsigned x;
    if (v > 32'd99999999) return 32'hEEEEEEEE;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk_axi);
    #1;
  endtask

  // Called at the sample just after the accept edge; counts edges until done.
  task automatic wait_done(output int n, output int busy_n, output logic stable);
    n = 0;
    busy_n = 0;
    stable = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      if (bcd_out !== prev_bcd) stable = 1'b0;
      step();
      n++;
    end
  endtask

  task automatic convert(input logic [31:0] v, input string tag);
    logic [31:0] exp;
    logic        ovf;
    int          n, busy_n, w;
    logic        stable;
    exp = bcd_ref(v);
    ovf = (v > 32'd99999999);
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    bin_in = v;
    bin_valid = 1'b1;
    step();
    bin_valid = 1'b0;
    bin_in = $urandom;
    wait_done(n, busy_n, stable);
    check({tag, " latency"}, 32'(n), ovf ? 32'd0 : 32'd27);
    check({tag, " busy_cycles"}, 32'(busy_n), ovf ? 32'd0 : 32'd27);
    check({tag, " stable"}, 32'(stable), 32'd1);
    check({tag, " bcd"}, bcd_out, exp);
    check({tag, " ovf"}, 32'(overflow), 32'(ovf));
    prev_bcd = exp;
    step();
    check({tag, " done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          n, busy_n, d0;
    logic        stable;
    logic [31:0] v;
    n_tests = 0;
    n_fail = 0;
    done_cnt = 0;
    prev_bcd = 32'h0;
    bin_in = 32'h0;
    bin_valid = 1'b0;
    reset = 1'b0;
    step();
    step();
    check("rst bcd", bcd_out, 32'h0);
    check("rst done", 32'(done), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    step();

    convert(32'd0, "zero");
    convert(32'd12345678, "1234");
    convert(32'd99999999, "max");
    convert(32'd100000000, "max+1");
    convert(32'hFFFFFFFF, "all1");
    convert(32'h08000000, "bit27");
    convert(32'd1, "one");
    convert(32'd5, "five");

    // Back-to-back with bin_valid held; bin_in changes after acceptance.
    d0 = done_cnt;
    bin_in = 32'd42;
    bin_valid = 1'b1;
    step();
    check("b2b busy0", 32'(busy), 32'd1);
    bin_in = 32'd7;
    wait_done(n, busy_n, stable);
    check("b2b lat42", 32'(n), 32'd27);
    check("b2b stable42", 32'(stable), 32'd1);
    check("b2b bcd42", bcd_out, 32'h00000042);
    check("b2b ready", 32'(in_ready), 32'd1);
    prev_bcd = 32'h00000042;
    step();
    bin_valid = 1'b0;
    check("b2b busy1", 32'(busy), 32'd1);
    wait_done(n, busy_n, stable);
    check("b2b lat7", 32'(n), 32'd27);
    check("b2b stable7", 32'(stable), 32'd1);
    check("b2b bcd7", bcd_out, 32'h00000007);
    prev_bcd = 32'h00000007;
    step();
    check("b2b done_pulses", 32'(done_cnt - d0), 32'd2);

    // Reset in the middle of a conversion.
    convert(32'd42, "pre_rst");
    bin_in = 32'd87654321;
    bin_valid = 1'b1;
    step();
    bin_valid = 1'b0;
    d0 = done_cnt;
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst bcd", bcd_out, 32'h0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ready", 32'(in_ready), 32'd1);
    check("midrst done", 32'(done), 32'd0);
    check("midrst ovf", 32'(overflow), 32'd0);
    prev_bcd = 32'h0;
    repeat (30) step();
    check("midrst no_done", 32'(done_cnt - d0), 32'd0);
    convert(32'd87654321, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      v = $urandom_range(0, 99999999);
      convert(v, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
